// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: one write port and two combinational read ports.
// The master drives addresses, write enable and write data; the slave returns read data.
interface reg_file_if #(
  parameter int data_width = 32,
  parameter int addr_width = 4
);
  logic                  we;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic [addr_width-1:0] read_addr1;
  logic [addr_width-1:0] read_addr2;
  logic [data_width-1:0] read_data1;
  logic [data_width-1:0] read_data2;

  modport master (
    output we, wr_addr, wr_data, read_addr1, read_addr2,
    input  read_data1, read_data2
  );

  modport slave (
    input  we, wr_addr, wr_data, read_addr1, read_addr2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: 2**addr_width x data_width, one synchronous write
// port, two asynchronous read ports. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file #(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   bus
);

  localparam int unsigned depth = 2 ** addr_width;

  logic [data_width-1:0] regs [depth];
  logic [data_width-1:0] rd1;
  logic [data_width-1:0] rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < depth; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd1 = regs[bus.read_addr1];
    rd2 = regs[bus.read_addr2];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so a dependent read sees it in the same cycle.
    if (rst_n && bus.we && (bus.read_addr1 == bus.wr_addr)) rd1 = bus.wr_data;
    if (rst_n && bus.we && (bus.read_addr2 == bus.wr_addr)) rd2 = bus.wr_data;
`endif
  end

  assign bus.read_data1 = rd1;
  assign bus.read_data2 = rd2;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected read data is queued when stimulus
// is driven and popped when the read ports are sampled.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 4;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  reg_file_if #(.data_width(DW), .addr_width(AW)) bus ();

  reg_file #(.data_width(DW), .addr_width(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned compared;
  int unsigned mismatched;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    bus.we = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 32'd99;
    bus.read_addr1 = 4'd3;
    bus.read_addr2 = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL reset_rd1: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL reset_rd2: got %0h expected %0h", bus.read_data2, e);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.we = 1'b0;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL reset_write_discarded: got %0h expected %0h", bus.read_data1, e);
    end
    bus.we = 1'b1;
    exp_q.push_back(32'd99);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL first_write_after_reset: got %0h expected %0h", bus.read_data1, e);
    end
  endtask

  task automatic test_write_latency;
    @(negedge clk);
    bus.we = 1'b1;
    bus.wr_addr = 4'd1;
    bus.wr_data = 32'd1;
    bus.read_addr1 = 4'd1;
    exp_q.push_back(BYPASS ? 32'd1 : 32'd0);
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL latency_pre_edge: got %0h expected %0h", bus.read_data1, e);
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL latency_post_edge: got %0h expected %0h", bus.read_data1, e);
    end
  endtask

  task automatic test_fill;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      bus.we = 1'b1;
      bus.wr_addr = AW'(n);
      bus.wr_data = DW'(n);
      if (n > 0) begin
        bus.read_addr1 = AW'(n - 1);
        exp_q.push_back(DW'(n - 1));
        #1;
        e = exp_q.pop_front(); compared++;
        if (bus.read_data1 !== e) begin
          mismatched++;
          $display("FAIL fill_trail[%0d]: got %0h expected %0h", n, bus.read_data1, e);
        end
      end
      exp_q.push_back(DW'(n));
      @(posedge clk);
      #1;
      bus.read_addr2 = AW'(n);
      #1;
      e = exp_q.pop_front(); compared++;
      if (bus.read_data2 !== e) begin
        mismatched++;
        $display("FAIL fill_written[%0d]: got %0h expected %0h", n, bus.read_data2, e);
      end
    end
    bus.we = 1'b0;
    @(negedge clk);
    bus.read_addr1 = 4'd7;
    bus.read_addr2 = 4'd7;
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd7);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL fill_rd1_7: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL fill_rd2_7: got %0h expected %0h", bus.read_data2, e);
    end
    bus.read_addr1 = 4'd5;
    bus.read_addr2 = 4'd6;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd6);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL fill_rd1_5: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL fill_rd2_6: got %0h expected %0h", bus.read_data2, e);
    end
  endtask

  task automatic test_write_disable;
    @(negedge clk);
    bus.we = 1'b0;
    bus.wr_addr = 4'd15;
    bus.wr_data = 32'd4;
    @(negedge clk);
    bus.wr_addr = 4'd7;
    bus.wr_data = 32'd15;
    @(negedge clk);
    bus.read_addr1 = 4'd15;
    bus.read_addr2 = 4'd7;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd7);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL wdis_reg15: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL wdis_reg7: got %0h expected %0h", bus.read_data2, e);
    end
    bus.wr_addr = 4'd3;
    bus.wr_data = 32'd23;
    @(negedge clk);
    bus.read_addr1 = 4'd3;
    exp_q.push_back(32'd3);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL wdis_reg3: got %0h expected %0h", bus.read_data1, e);
    end
  endtask

  task automatic test_dual_port;
    @(negedge clk);
    bus.read_addr1 = 4'd9;
    bus.read_addr2 = 4'd9;
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd9);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL dual_same_rd1: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL dual_same_rd2: got %0h expected %0h", bus.read_data2, e);
    end
    bus.read_addr2 = 4'd10;
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd10);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL dual_split_rd1: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL dual_split_rd2: got %0h expected %0h", bus.read_data2, e);
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    bus.we = 1'b1;
    bus.wr_addr = 4'd2;
    bus.wr_data = 32'd30;
    bus.read_addr1 = 4'd2;
    bus.read_addr2 = 4'd2;
    exp_q.push_back(BYPASS ? 32'd30 : 32'd2);
    exp_q.push_back(BYPASS ? 32'd30 : 32'd2);
    exp_q.push_back(32'd30);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL rdw_pre_edge_rd1: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL rdw_pre_edge_rd2: got %0h expected %0h", bus.read_data2, e);
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL rdw_post_edge: got %0h expected %0h", bus.read_data1, e);
    end
  endtask

  task automatic test_reset_midsim;
    @(negedge clk);
    bus.we = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 32'd3;
    bus.read_addr1 = 4'd3;
    bus.read_addr2 = 4'd9;
    exp_q.push_back(32'd3);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL midrst_before: got %0h expected %0h", bus.read_data1, e);
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data1 !== e) begin
      mismatched++;
      $display("FAIL midrst_async_rd1: got %0h expected %0h", bus.read_data1, e);
    end
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL midrst_async_rd2: got %0h expected %0h", bus.read_data2, e);
    end
    bus.we = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 32'd55;
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); compared++;
    if (bus.read_data2 !== e) begin
      mismatched++;
      $display("FAIL midrst_write_discarded: got %0h expected %0h", bus.read_data2, e);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_write_latency();
    test_fill();
    test_write_disable();
    test_dual_port();
    test_bypass();
    test_reset_midsim();
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parameterised multi-ported register file: 2**addr_width words of data_width bits.
- One synchronous write port and two independent asynchronous (combinational) read ports.
- Serves as the architectural register storage in the CPU datapath, feeding ALU operands.
- Writes become visible one cycle after presentation; reads reflect current contents immediately.

Parameters:
- data_width, 32, bit width of each register and of all data ports
- addr_width, 4, address width; depth = 2**addr_width (16 registers by default)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable, sampled at rising clk
- wr_addr  input  addr_width  write register index
- wr_data  input  data_width  write data
- read_addr1  input  addr_width  read port 1 register index
- read_addr2  input  addr_width  read port 2 register index
- read_data1  output  data_width  contents of register read_addr1
- read_data2  output  data_width  contents of register read_addr2

Behaviour:
- Clocking/reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: rst_n low immediately clears every register to 0, independent of clk. read_data1/2 then read 0 for any address.
- Reset is held for as long as rst_n is low; a write attempted during reset is discarded.
- Deassertion of rst_n takes effect without waiting for a clock edge. The first write is accepted at the first rising clk edge with rst_n high.
- Write: at rising clk with rst_n high and we=1, the register at wr_addr loads wr_data. With we=0, no register changes, regardless of wr_addr/wr_data.
- Write latency: new value visible on read ports after the capturing edge, i.e. one cycle after inputs were presented.
- Read: purely combinational. read_dataN = reg[read_addrN] in the same cycle the address changes; no clock involved.
- Both read ports are fully independent. The same address on both ports returns identical data.
- Read-during-write, same address, same cycle: the read port returns the OLD contents until the edge, then the new value (baseline, no bypass).
- All addresses 0..2**addr_width-1 are valid and writable, including 0; no hardwired-zero register. No out-of-range case exists.
- X/unknown on wr_addr while we=1 is a bench error. The design is not required to handle it.
- Storage is plain flip-flops/array; no output registers.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined: write-to-read forwarding. When we=1 and read_addrN == wr_addr (rst_n high), read_dataN = wr_data combinationally in the same cycle. Applies independently per read port.
- Not defined: no forwarding; read-during-write returns the pre-edge contents as in Behaviour.
- Write timing and reset behaviour are identical in both builds.

Test Plan:
- Reset: pulse rst_n low mid-simulation after writing reg3=3 -> read_data1 with read_addr1=3 drops to 0 immediately, without a clk edge.
- Write latency, no bypass: we=1, wr_addr=1, wr_data=1, read_addr1=1 -> read_data1=0 before the edge, =1 after the edge.
- Sequential fill: write reg N = N for N=0..11 with we=1, reading trailing addresses each cycle.
  - read_addr1=7, read_addr2=7 -> both ports 7.
  - read_addr1=5, read_addr2=6 -> 5 and 6.
- Write disable: we=0, wr_addr=15, wr_data=4, then wr_addr=7, wr_data=15 -> reading 15 gives 0 and reading 7 gives 7. Repeat with wr_addr=3, wr_data=23 -> reg3 stays 3.
- Dual port, same address: read_addr1=read_addr2=9 after reg9=9 -> both outputs 9 in the same cycle. Changing read_addr2 to 10 updates only read_data2, combinationally.
- Bypass build (REG_FILE_BYPASS_EN): we=1, wr_addr=2, wr_data=30, read_addr1=2 -> read_data1=30 before the edge. The same stimulus in the non-bypass build returns the old value 2.
